xoodyak_msg_packer: RTL and testbench



---
 rtl/xoodyak_pkg.sv | 17 +
 rtl/xoodyak_msg_packer_if.sv | 41 ++++
 rtl/xoodyak_pad_insert.sv | 29 ++
 rtl/xoodyak_msg_packer.sv | 127 ++++++++++++
 tb/tb_xoodyak_msg_packer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xoodyak_pkg.sv
// Shared constants and types for the Xoodyak hash absorb front end.
package xoodyak_pkg;

  localparam int         RATE_BYTES = 16;
  localparam logic [7:0] PAD_BYTE   = 8'h01;
  localparam int         LEN_W      = 12;

  localparam int BLK_BYTES = RATE_BYTES + 1;
  localparam int BLK_W     = 8 * BLK_BYTES;
  localparam int CNT_W     = 5;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } pack_state_e;

endpackage

// File: rtl/xoodyak_msg_packer_if.sv
// Message byte stream in, absorb block stream out.
// msg_len_out exists only when XOODYAK_LEN_CNT_EN is defined.
interface xoodyak_msg_packer_if;
  import xoodyak_pkg::*;

  logic [7:0]       msg_byte;
  logic             msg_valid;
  logic             msg_last;
  logic             msg_empty;
  logic             msg_ready;
  logic [BLK_W-1:0] blk_data;
  logic [CNT_W-1:0] blk_nbytes;
  logic             blk_first;
  logic             blk_last;
  logic             blk_valid;
  logic             blk_ready;
`ifdef XOODYAK_LEN_CNT_EN
  logic [LEN_W-1:0] msg_len_out;

  modport master (
    output msg_byte, msg_valid, msg_last, msg_empty, blk_ready,
    input  msg_ready, blk_data, blk_nbytes, blk_first, blk_last, blk_valid, msg_len_out
  );

  modport slave (
    input  msg_byte, msg_valid, msg_last, msg_empty, blk_ready,
    output msg_ready, blk_data, blk_nbytes, blk_first, blk_last, blk_valid, msg_len_out
  );
`else
  modport master (
    output msg_byte, msg_valid, msg_last, msg_empty, blk_ready,
    input  msg_ready, blk_data, blk_nbytes, blk_first, blk_last, blk_valid
  );

  modport slave (
    input  msg_byte, msg_valid, msg_last, msg_empty, blk_ready,
    output msg_ready, blk_data, blk_nbytes, blk_first, blk_last, blk_valid
  );
`endif

endinterface

// File: rtl/xoodyak_pad_insert.sv
// Writes one message byte into the block buffer at position cnt and, on the
// final byte, drops the Down-padding byte into the slot right after it.
module xoodyak_pad_insert
  import xoodyak_pkg::*;
(
  input  logic [BLK_W-1:0] data_in,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [7:0]       byte_in,
  input  logic             last_in,
  output logic [BLK_W-1:0] data_out
);

  logic [CNT_W-1:0] pad_pos;

  // cnt_in never exceeds RATE_BYTES-1 here, so the pad always lands within byte 16.
  assign pad_pos = cnt_in + CNT_W'(1);

  always_comb begin
    data_out = data_in;
    for (int k = 0; k < BLK_BYTES; k++) begin
      if (CNT_W'(k) == cnt_in) begin
        data_out[8*k +: 8] = byte_in;
      end else if (last_in && (CNT_W'(k) == pad_pos)) begin
        data_out[8*k +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/xoodyak_msg_packer.sv
// Packs a byte stream into 17-byte Xoodyak absorb blocks with Down padding.
// Optional total-length counter on msg_len_out under XOODYAK_LEN_CNT_EN.
module xoodyak_msg_packer
  import xoodyak_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  xoodyak_msg_packer_if.slave  bus
);

  pack_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_pending_q, first_pending_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] nbytes_q, nbytes_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [BLK_W-1:0] padded;
  logic             msg_ready;
  logic             accept;

  assign msg_ready = (state_q == FILL) && !bus.msg_empty;
  assign accept    = bus.msg_valid && msg_ready;

  xoodyak_pad_insert u_pad_insert (
    .data_in  (data_q),
    .cnt_in   (cnt_q),
    .byte_in  (bus.msg_byte),
    .last_in  (bus.msg_last),
    .data_out (padded)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    first_pending_d = first_pending_q;
    data_d          = data_q;
    nbytes_d        = nbytes_q;
    first_d         = first_q;
    last_d          = last_q;
    case (state_q)
      FILL: begin
        if (bus.msg_empty) begin
          // A zero-length message is only legal at a message boundary.
          if ((cnt_q == '0) && first_pending_q) begin
            data_d   = BLK_W'(PAD_BYTE);
            nbytes_d = '0;
            first_d  = 1'b1;
            last_d   = 1'b1;
            state_d  = EMIT;
          end
        end else if (accept) begin
          data_d = padded;
          cnt_d  = cnt_q + CNT_W'(1);
          if (bus.msg_last) begin
            nbytes_d = cnt_q + CNT_W'(1);
            first_d  = first_pending_q;
            last_d   = 1'b1;
            state_d  = EMIT;
          end else if (cnt_q == CNT_W'(RATE_BYTES - 1)) begin
            nbytes_d = CNT_W'(RATE_BYTES);
            first_d  = first_pending_q;
            last_d   = 1'b0;
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        if (bus.blk_ready) begin
          data_d          = '0;
          cnt_d           = '0;
          first_pending_d = last_q;
          state_d         = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      cnt_q           <= '0;
      first_pending_q <= 1'b1;
      data_q          <= '0;
      nbytes_q        <= '0;
      first_q         <= 1'b0;
      last_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      first_pending_q <= first_pending_d;
      data_q          <= data_d;
      nbytes_q        <= nbytes_d;
      first_q         <= first_d;
      last_q          <= last_d;
    end
  end

  assign bus.msg_ready  = msg_ready;
  assign bus.blk_data   = data_q;
  assign bus.blk_nbytes = nbytes_q;
  assign bus.blk_first  = first_q;
  assign bus.blk_last   = last_q;
  assign bus.blk_valid  = (state_q == EMIT);

`ifdef XOODYAK_LEN_CNT_EN
  logic [LEN_W-1:0] len_q;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
    end else if ((state_q == EMIT) && bus.blk_ready && last_q) begin
      len_q <= '0;
    end else if (accept) begin
      len_q <= sat_inc(len_q);
    end
  end

  assign bus.msg_len_out = len_q;
`endif

endmodule

// File: tb/tb_xoodyak_msg_packer.sv
// Directed bench for xoodyak_msg_packer: message-level block model plus literal checks.
module tb_xoodyak_msg_packer;
  import xoodyak_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xoodyak_msg_packer_if bus ();

  xoodyak_msg_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [135:0] data;
    int           nbytes;
    bit           first;
    bit           last;
    int           len;
  } blk_t;

  blk_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [135:0] snap_data;
  int           snap_nbytes;
  bit           snap_valid, snap_first, snap_last;
  int           snap_len;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected blocks for a message of n bytes base, base+1, ...: split into
  // 16-byte chunks; the final chunk carries the pad right after its data.
  function automatic void model_msg(input int n, input logic [7:0] base);
    blk_t b;
    int   nblk, chunk;
    if (n == 0) begin
      b.data = '0; b.data[7:0] = 8'h01; b.nbytes = 0; b.first = 1; b.last = 1; b.len = 0;
      exp_q.push_back(b);
      return;
    end
    nblk = (n + 15) / 16;
    for (int j = 0; j < nblk; j++) begin
      chunk  = (n - 16*j > 16) ? 16 : n - 16*j;
      b.data = '0;
      for (int i = 0; i < chunk; i++) b.data[8*i +: 8] = base + 8'(16*j + i);
      b.last   = (j == nblk - 1);
      if (b.last) b.data[8*chunk +: 8] = 8'h01;
      b.nbytes = chunk;
      b.first  = (j == 0);
      b.len    = n;
      exp_q.push_back(b);
    end
  endfunction

  // Per-cycle comparison against the model whenever a block is presented.
  always @(negedge clk) begin
    if (!reset) begin
      chk("msg_ready", bus.msg_ready, !bus.blk_valid && !bus.msg_empty);
      if (bus.blk_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_block: got data %h expected no block", bus.blk_data);
        end else begin
          chk("blk_data",   bus.blk_data,   exp_q[0].data);
          chk("blk_nbytes", bus.blk_nbytes, exp_q[0].nbytes);
          chk("blk_first",  bus.blk_first,  exp_q[0].first);
          chk("blk_last",   bus.blk_last,   exp_q[0].last);
`ifdef XOODYAK_LEN_CNT_EN
          if (bus.blk_last) chk("msg_len_out", bus.msg_len_out, exp_q[0].len);
`endif
          if (bus.blk_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic take_snap();
    snap_valid  = bus.blk_valid;
    snap_data   = bus.blk_data;
    snap_nbytes = int'(bus.blk_nbytes);
    snap_first  = bus.blk_first;
    snap_last   = bus.blk_last;
`ifdef XOODYAK_LEN_CNT_EN
    snap_len    = int'(bus.msg_len_out);
`else
    snap_len    = 0;
`endif
  endtask

  // Sends n bytes; stops early (no last) once abort_at bytes were accepted.
  // Snapshots the block outputs on the half-cycle after the final transfer.
  task automatic send_msg(input int n, input logic [7:0] base, input int abort_at);
    bit acc;
    int cyc;
    for (int i = 0; i < n; i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      bus.msg_byte  = base + 8'(i);
      bus.msg_valid = 1'b1;
      bus.msg_last  = (i == n - 1);
      acc = 0; cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge clk);
        acc = bus.msg_ready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted within %0d cycles", i, cyc);
        break;
      end
    end
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    @(negedge clk);
    take_snap();
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("blocks_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.msg_byte  = '0;
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.msg_empty = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_valid",  bus.blk_valid,  0);
    chk("rst_blk_data",   bus.blk_data,   0);
    chk("rst_blk_nbytes", bus.blk_nbytes, 0);
    chk("rst_blk_first",  bus.blk_first,  0);
    chk("rst_blk_last",   bus.blk_last,   0);
    chk("rst_msg_ready",  bus.msg_ready,  1);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: 12-byte message, block valid one cycle after the last byte
    model_msg(12, 8'h00);
    send_msg(12, 8'h00, -1);
    chk("t1_latency", snap_valid, 1);
    chk("t1_data_lo", snap_data[103:0], 104'h010B0A09080706050403020100);
    chk("t1_data_hi", snap_data[135:104], 32'h0);
    chk("t1_nbytes",  snap_nbytes, 12);
    chk("t1_first_last", {snap_first, snap_last}, 2'b11);
    drain();

    // 2: msg_empty wins over a simultaneous valid byte
    model_msg(0, 8'h00);
    bus.msg_empty = 1'b1; bus.msg_valid = 1'b1; bus.msg_byte = 8'hAA;
    @(posedge clk); #1;
    bus.msg_empty = 1'b0; bus.msg_valid = 1'b0;
    @(negedge clk);
    take_snap();
    chk("t2_valid",  snap_valid, 1);
    chk("t2_data",   snap_data, 136'h01);
    chk("t2_nbytes", snap_nbytes, 0);
    chk("t2_first_last", {snap_first, snap_last}, 2'b11);
    drain();

    // 3: exactly 16 bytes, pad in byte 16
    model_msg(16, 8'h00);
    send_msg(16, 8'h00, -1);
    chk("t3_byte16", snap_data[135:128], 8'h01);
    chk("t3_nbytes", snap_nbytes, 16);
    chk("t3_last",   snap_last, 1);
    drain();

    // 4: 17 bytes split into two blocks
    model_msg(17, 8'h00);
    send_msg(17, 8'h00, -1);
    chk("t4b_data",   snap_data, 136'h0110);
    chk("t4b_nbytes", snap_nbytes, 1);
    chk("t4b_first_last", {snap_first, snap_last}, 2'b01);
    drain();

    // 5: back-pressure on block A for five cycles while bytes wait
    model_msg(17, 8'h00);
    bus.blk_ready = 1'b0;
    fork
      send_msg(17, 8'h00, -1);
      begin
        int cyc = 0;
        @(negedge clk);
        while (!bus.blk_valid && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t5_blockA_seen", bus.blk_valid, 1);
        repeat (5) begin
          chk("t5_stall_ready",  bus.msg_ready, 0);
          chk("t5_stall_data",   bus.blk_data, 136'h0F0E0D0C0B0A09080706050403020100);
          chk("t5_stall_nbytes", bus.blk_nbytes, 16);
          chk("t5_stall_last",   bus.blk_last, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.blk_ready = 1'b1;
      end
    join
    chk("t5b_data",   snap_data, 136'h0110);
    chk("t5b_nbytes", snap_nbytes, 1);
`ifdef XOODYAK_LEN_CNT_EN
    chk("t5b_len", snap_len, 17);
`endif
    drain();

    // 6: reset mid-message, then a clean 3-byte message
    send_msg(12, 8'h40, 7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", bus.blk_valid, 0);
    chk("t6_rst_data",  bus.blk_data, 0);
    chk("t6_rst_nbytes", bus.blk_nbytes, 0);
`ifdef XOODYAK_LEN_CNT_EN
    chk("t6_rst_len", bus.msg_len_out, 0);
`endif
    @(posedge clk); #1;
    model_msg(3, 8'h00);
    send_msg(3, 8'h00, -1);
    chk("t6_data",   snap_data, 136'h01020100);
    chk("t6_nbytes", snap_nbytes, 3);
    chk("t6_first",  snap_first, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
